// File: rtl/dvsd_div16by8_pkg.sv
// Shared types and constants for the sequential 16-by-8 restoring divider.
package dvsd_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int         DW_N      = 16;
   localparam int         DW_D      = 8;
   localparam logic [3:0] ITER_LAST = 4'd15;

endpackage

// File: rtl/dvsd_div16by8_step.sv
// One radix-2 restoring division step: shift in a dividend bit, try a
// subtraction of the divisor and keep the difference only if it did not borrow.
module dvsd_div_step #(
   parameter int W = 8
) (
   input  logic [W-1:0] part_rem,
   input  logic         next_bit,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] new_rem,
   output logic         q_bit
);

   logic [W:0] partial_s;
   logic [W:0] trial_s;

   // Trial subtraction; bit W of the difference is the borrow (negative result).
   always_comb begin
      partial_s = {part_rem, next_bit};
      trial_s   = partial_s - {1'b0, divisor};
      if (trial_s[W] == 1'b0) begin
         new_rem = trial_s[W-1:0];
         q_bit   = 1'b1;
      end else begin
         new_rem = partial_s[W-1:0];
         q_bit   = 1'b0;
      end
   end

endmodule

// File: rtl/dvsd_div16by8.sv
// Sequential 16-by-8 unsigned divider, one quotient bit per clock, with a
// start/done handshake. A zero divisor completes in one cycle with a flag.
module dvsd_div16by8 #(
   parameter int DW_N = 16,
   parameter int DW_D = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [DW_N-1:0] dividend,
   input  logic [DW_D-1:0] divisor,
   output logic            busy,
   output logic            done,
   output logic [DW_N-1:0] quotient,
   output logic [DW_D-1:0] remainder,
   output logic            div_by_zero
);

   import dvsd_div_pkg::*;

   div_state_t      state_r;
   logic [3:0]      cnt_r;
   logic [DW_N-1:0] shift_r;   // dividend bits shift out the top, quotient bits in at the bottom
   logic [DW_D-1:0] rem_r;
   logic [DW_D-1:0] dvs_r;
   logic [DW_D-1:0] step_rem_s;
   logic            step_q_s;

   dvsd_div_step #(
      .W (DW_D)
   ) u_step (
      .part_rem (rem_r),
      .next_bit (shift_r[DW_N-1]),
      .divisor  (dvs_r),
      .new_rem  (step_rem_s),
      .q_bit    (step_q_s)
   );

   // Control FSM, iteration counter, operand shift register and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         cnt_r       <= 4'd0;
         shift_r     <= {DW_N{1'b0}};
         rem_r       <= {DW_D{1'b0}};
         dvs_r       <= {DW_D{1'b0}};
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= {DW_N{1'b0}};
         remainder   <= {DW_D{1'b0}};
         div_by_zero <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  if (divisor == {DW_D{1'b0}}) begin
                     // Zero divisor: report saturated quotient immediately.
                     state_r     <= DONE;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                     quotient    <= {DW_N{1'b1}};
                     remainder   <= {DW_D{1'b0}};
                     div_by_zero <= 1'b1;
                  end else begin
                     state_r <= RUN;
                     busy    <= 1'b1;
                     shift_r <= dividend;
                     dvs_r   <= divisor;
                     rem_r   <= {DW_D{1'b0}};
                     cnt_r   <= 4'd0;
                  end
               end else begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end
            end
            RUN: begin
               // start is deliberately ignored here; operands stay latched.
               shift_r <= {shift_r[DW_N-2:0], step_q_s};
               rem_r   <= step_rem_s;
               cnt_r   <= cnt_r + 4'd1;
               if (cnt_r == ITER_LAST) begin
                  state_r     <= DONE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  quotient    <= {shift_r[DW_N-2:0], step_q_s};
                  remainder   <= step_rem_s;
                  div_by_zero <= 1'b0;
               end else begin
                  state_r <= RUN;
                  busy    <= 1'b1;
                  done    <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dvsd_div16by8.sv
// Directed and random checks of dvsd_div16by8 with an expected-result queue.
module tb_dvsd_div16by8;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        div_by_zero;

   typedef struct {
      logic [15:0] q;
      logic [7:0]  r;
      logic        dbz;
      logic [15:0] a;
      logic [7:0]  b;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   dvsd_div16by8 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
      exp_t e;
      e.a = a;
      e.b = b;
      if (b == 8'd0) begin
         e.q = 16'hFFFF; e.r = 8'd0; e.dbz = 1'b1;
      end else begin
         e.q = a / {8'd0, b}; e.r = 8'(a % {8'd0, b}); e.dbz = 1'b0;
      end
      return e;
   endfunction

   // Drive a request for one edge (called just after a negedge); optionally queue its result.
   task automatic issue(input logic [15:0] a, input logic [7:0] b, input bit push, input bit hold);
      start = 1'b1; dividend = a; divisor = b;
      if (push) exp_q.push_back(model(a, b));
      @(posedge clk);
      @(negedge clk);
      if (!hold) start = 1'b0;
      chk("busy_after_start", {31'd0, busy}, {31'd0, (b != 8'd0) ? 1'b0 : 1'b0} | ((b != 8'd0) ? 32'd1 : 32'd0));
   endtask

   // Wait for done (checking latency and busy), then pop and compare the result.
   // pulse_at > 0 injects a start with other operands at that cycle.
   task automatic wait_done(input int exp_lat, input int pulse_at, input bit zero_op);
      int n;
      bit busy_ok;
      exp_t e;
      busy_ok = 1'b1;
      n = zero_op ? 1 : 0;
      while (!done && n < 40) begin
         if (!busy) busy_ok = 1'b0;
         @(negedge clk);
         n++;
         if (start && pulse_at > 0) start = 1'b0;
         if (n == pulse_at) begin
            start = 1'b1; dividend = 16'd50; divisor = 8'd5;
         end
      end
      chk("busy_during_run", {31'd0, busy_ok}, 32'd1);
      chk("done_latency", n, exp_lat);
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0 + {31'd0, done} - 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk("quotient", {16'd0, quotient}, {16'd0, e.q});
         chk("remainder", {24'd0, remainder}, {24'd0, e.r});
         chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
         if (!e.dbz) begin
            chk("invariant", {16'd0, quotient} * {24'd0, e.b} + {24'd0, remainder}, {16'd0, e.a});
            chk("rem_lt_div", {31'd0, remainder < e.b}, 32'd1);
         end
      end
   endtask

   initial begin
      int n;
      bit seen_done;
      start = 1'b0; dividend = 16'd0; divisor = 8'd0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_quotient", {16'd0, quotient}, 32'd0);
      chk("reset_remainder", {24'd0, remainder}, 32'd0);
      chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1000 / 7
      issue(16'd1000, 8'd7, 1'b1, 1'b0);
      wait_done(16, 0, 1'b0);
      @(negedge clk);
      chk("done_single_pulse", {31'd0, done}, 32'd0);

      // 65535 / 255, then 5 / 9
      issue(16'd65535, 8'd255, 1'b1, 1'b0);
      wait_done(16, 0, 1'b0);
      @(negedge clk);
      issue(16'd5, 8'd9, 1'b1, 1'b0);
      wait_done(16, 0, 1'b0);
      @(negedge clk);

      // divide by zero
      issue(16'h1234, 8'd0, 1'b1, 1'b0);
      wait_done(1, 0, 1'b1);
      @(negedge clk);
      chk("dbz_done_pulse", {31'd0, done}, 32'd0);
      chk("dbz_busy", {31'd0, busy}, 32'd0);

      // start pulsed during RUN is ignored
      issue(16'd1000, 8'd7, 1'b1, 1'b0);
      wait_done(16, 8, 1'b0);
      @(negedge clk);
      chk("ignore_no_restart", {31'd0, busy}, 32'd0);

      // reset mid-operation
      issue(16'd60000, 8'd200, 1'b0, 1'b0);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_quotient", {16'd0, quotient}, 32'd0);
      chk("abort_remainder", {24'd0, remainder}, 32'd0);
      seen_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      chk("abort_no_done", {31'd0, seen_done}, 32'd0);
      issue(16'd300, 8'd10, 1'b1, 1'b0);
      wait_done(16, 0, 1'b0);
      @(negedge clk);

      // start held high across DONE: back-to-back without an IDLE cycle
      exp_q.push_back(model(16'd200, 8'd3));
      exp_q.push_back(model(16'd255, 8'd16));
      issue(16'd200, 8'd3, 1'b0, 1'b1);
      dividend = 16'd255; divisor = 8'd16;
      wait_done(16, 0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", {31'd0, busy}, 32'd1);
      chk("b2b_done_low", {31'd0, done}, 32'd0);
      wait_done(16, 0, 1'b0);
      @(negedge clk);

      // random operands
      for (int i = 0; i < 2000; i++) begin
         issue(16'($urandom_range(0, 65535)), 8'($urandom_range(1, 255)), 1'b1, 1'b0);
         wait_done(16, 0, 1'b0);
         @(negedge clk);
      end

      n = exp_q.size();
      chk("scoreboard_drained", n, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dvsd_div16by8.md
# dvsd_div16by8

Sequential 16-by-8 unsigned integer divider. It is the inverse companion of the team's 8x8 array multiplier: a 16-bit product can be divided back by one 8-bit factor. It uses radix-2 restoring division, one quotient bit per clock, behind a start/done handshake. It sits beside the multiplier in the datapath and serves the multiply-check and scaling paths.

## Interface
Parameters:
- `DW_N`, default 16: dividend and quotient width. Only 16 is supported.
- `DW_D`, default 8: divisor and remainder width. Only 8 is supported.

Ports:
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a division. Sampled only when the FSM is in IDLE or DONE.
- `dividend` input 16: unsigned dividend. Sampled with an accepted `start`.
- `divisor` input 8: unsigned divisor. Sampled with an accepted `start`.
- `busy` output 1: high while a division is in progress.
- `done` output 1: one-cycle pulse. Results are valid while it is high.
- `quotient` output 16: unsigned quotient, registered.
- `remainder` output 8: unsigned remainder, registered.
- `div_by_zero` output 1: high with `done` when the divisor was 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, no `start`: remain in IDLE.
- IDLE or DONE with `start`, divisor != 0: latch the operands, clear the partial remainder and the iteration counter, go to RUN.
- IDLE or DONE with `start`, divisor == 0: go to DONE directly. Set `quotient`=16'hFFFF, `remainder`=8'h00, `div_by_zero`=1.
- DONE without `start`: go to IDLE.
- RUN, one iteration per cycle:
  - Form a 9-bit partial remainder P = {R[7:0], dividend MSB}, then shift the dividend left by 1.
  - Compute the trial difference T = P − {1'b0, divisor}.
  - If T is non-negative (bit 8 clear): R ← T[7:0] and the new quotient LSB is 1.
  - Otherwise: R ← P[7:0] and the quotient LSB is 0.
  - The quotient shifts into the vacated dividend bits.
- Counter: 4 bits, counts 0..15. At count 15 the final iteration writes `quotient` and `remainder`, clears `div_by_zero`, and the FSM goes to DONE.
- `start` while in RUN is ignored. Operands are not re-sampled and the running division is unaffected.
- `quotient`, `remainder` and `div_by_zero` hold their values until the next completion or reset. They do not change during RUN.
- All arithmetic is unsigned, and there is no overflow: 16/8 always fits in a 16-bit quotient.
- Invariant: quotient*divisor + remainder == dividend, and remainder < divisor.

## Timing
- Reset values (asynchronous, applied immediately): FSM=IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, internal registers 0.
- Reset mid-operation aborts the division. No `done` pulse is produced for the aborted operation.
- Normal division, with `start` accepted at edge k:
  - `busy`=1 from edge k until edge k+16.
  - At edge k+16, `done`=1, results are valid, and `busy`=0.
  - At edge k+17, `done`=0. Latency is 16 cycles.
- Divide by zero, with `start` accepted at edge k: `done`=1 and `div_by_zero`=1 from edge k to edge k+1, and `busy` stays 0. Latency is 1 cycle.
- Back-to-back operation: a `start` in the DONE cycle is accepted. The next operation begins without an IDLE cycle, giving a throughput of 1 division per 17 cycles.
- `done` is never high for two consecutive cycles, unless two divide-by-zero operations are issued back-to-back.

## Structure
- Package `dvsd_div_pkg` contains:
  - The `div_state_t` enum (IDLE, RUN, DONE).
  - Constants `DW_N`=16, `DW_D`=8, `ITER_LAST`=4'd15.
- Sub-module `dvsd_div_step`: purely combinational single restoring step.
  - Inputs: 8-bit remainder, incoming bit, 8-bit divisor.
  - Outputs: new 8-bit remainder and quotient bit.
  - It is instantiated once inside `dvsd_div16by8`.
- Top level contains the FSM, the counter, the operand/shift register, and the result registers.

## Test plan
- 1000 / 7 → `done` exactly 16 cycles after `start`, `quotient`=142, `remainder`=6, `div_by_zero`=0, `busy` high for 16 cycles.
- 65535 / 255 → `quotient`=257, `remainder`=0; then 5 / 9 → `quotient`=0, `remainder`=5.
- 16'h1234 / 0 → `done` and `div_by_zero` high 1 cycle after `start`, `quotient`=16'hFFFF, `remainder`=0, `busy` never asserted.
- 1000 / 7 issued, then `start` pulsed with 50 / 5 at cycle 8 during RUN → ignored; the result is still 142 r 6.
- `rst_n` pulled low at cycle 10 of 60000 / 200 → all outputs 0 immediately, no `done`. After release, 300 / 10 completes with 30 r 0.
- `start` held high across DONE with 200 / 3 followed by 255 / 16 → results 66 r 2, then 15 r 15 after a further 16 cycles. Over 2000 random operand pairs, quotient*divisor + remainder == dividend and remainder < divisor.
